// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait handling with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_we_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MEM_WAIT,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              load_use;
    logic              run_decode;
    logic              err_set;
    logic              stall_cyc;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_memread_i && (ex_rd_addr_i != '0) &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        run_decode    = 1'b0;
        err_set       = 1'b0;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_we_o    = 1'b0;
        memwb_we_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end
            end
            S_RUN: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (mem_req_i && !mem_ack_i) begin
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    run_decode = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (!mem_ack_i) begin
                    if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_ERROR;
                        err_set = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    // ack cycle: pipeline resumes with the normal hazard decode
                    run_decode = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (run_decode) begin
            if (load_use) begin
                idex_bubble_o = 1'b1;
                exmem_we_o    = 1'b1;
                memwb_we_o    = 1'b1;
            end else begin
                pc_we_o      = 1'b1;
                ifid_we_o    = 1'b1;
                exmem_we_o   = 1'b1;
                memwb_we_o   = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    assign stall_cyc = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_we_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            stall_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (err_set) begin
                err_o <= 1'b1;
            end
            if (stall_cyc && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. A second instance with CNT_W=4 checks saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        memread = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;

    logic        pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, err;
    logic [31:0] cnt;
    logic        pc_we4, ifid_we4, ifid_flush4, idex_bubble4, exmem_we4, memwb_we4, err4;
    logic [3:0]  cnt4;

    localparam logic [5:0] EN_ALL = 6'b110011;
    localparam logic [5:0] EN_OFF = 6'b000000;
    localparam logic [5:0] EN_LU  = 6'b000111;
    localparam logic [5:0] EN_BR  = 6'b111011;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_memread_i(memread), .ex_rd_addr_i(rd), .branch_taken_i(br),
        .mem_req_i(req), .mem_ack_i(ack),
        .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .exmem_we_o(exmem_we), .memwb_we_o(memwb_we),
        .stall_cnt_o(cnt), .err_o(err)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_memread_i(memread), .ex_rd_addr_i(rd), .branch_taken_i(br),
        .mem_req_i(req), .mem_ack_i(ack),
        .pc_we_o(pc_we4), .ifid_we_o(ifid_we4), .ifid_flush_o(ifid_flush4),
        .idex_bubble_o(idex_bubble4), .exmem_we_o(exmem_we4), .memwb_we_o(memwb_we4),
        .stall_cnt_o(cnt4), .err_o(err4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  en;
        logic        cc;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        mx;
    logic [5:0]  act;
    logic [3:0]  want4;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [4:0] a1, input logic [4:0] a2,
                         input logic m, input logic [4:0] d, input logic b,
                         input logic rq, input logic ak);
        start_i = st; rs1 = a1; rs2 = a2; memread = m; rd = d; br = b; req = rq; ack = ak;
    endtask

    task automatic expect_out(input string nm, input logic [5:0] en, input logic cc,
                              input logic [31:0] c, input logic e);
        exp_t x;
        x.name = nm; x.en = en; x.cc = cc; x.cnt = c; x.err = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mx  = q.pop_front();
            act = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we};
            n_cmp++;
            if (act !== mx.en) begin
                n_bad++;
                $display("FAIL %s enables {pc,ifid,flush,bubble,exmem,memwb}: got %b want %b",
                         mx.name, act, mx.en);
            end
            n_cmp++;
            if (err !== mx.err) begin
                n_bad++;
                $display("FAIL %s err_o: got %b want %b", mx.name, err, mx.err);
            end
            if (mx.cc) begin
                n_cmp++;
                if (cnt !== mx.cnt) begin
                    n_bad++;
                    $display("FAIL %s stall_cnt_o: got %0d want %0d", mx.name, cnt, mx.cnt);
                end
                want4 = (mx.cnt > 32'd15) ? 4'd15 : mx.cnt[3:0];
                n_cmp++;
                if (cnt4 !== want4) begin
                    n_bad++;
                    $display("FAIL %s stall_cnt_o(CNT_W=4): got %0d want %0d", mx.name, cnt4, want4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); expect_out("reset", EN_OFF, 1, 0, 0);
        tick(); rst_i = 1'b1; drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("idle_first", EN_OFF, 1, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("run_clean", EN_ALL, 1, 0, 0);
        tick(); drive(1, 1, 2, 0, 3, 0, 0, 0); expect_out("run_nomemread", EN_ALL, 1, 0, 0);

        // load-use and branch
        tick(); drive(1, 1, 5, 1, 5, 1, 0, 0); expect_out("lu_rs2_branch", EN_LU, 1, 0, 0);
        tick(); drive(1, 1, 5, 0, 5, 1, 0, 0); expect_out("branch_after_lu", EN_BR, 1, 1, 0);
        tick(); drive(1, 0, 0, 1, 0, 0, 0, 0); expect_out("lu_rd_x0", EN_ALL, 1, 1, 0);
        tick(); drive(1, 7, 3, 1, 7, 0, 0, 0); expect_out("lu_rs1", EN_LU, 1, 1, 0);
        tick(); drive(1, 7, 3, 1, 9, 0, 0, 0); expect_out("memread_nomatch", EN_ALL, 1, 2, 0);

        // memory wait of three stall cycles
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("mem_miss", EN_OFF, 1, 2, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("mem_wait1", EN_OFF, 1, 3, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("mem_wait2", EN_OFF, 1, 4, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 1); expect_out("mem_wait_ack", EN_ALL, 1, 5, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 1); expect_out("mem_hit", EN_ALL, 1, 5, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("run_after_mem", EN_ALL, 1, 5, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("mem_miss2", EN_OFF, 1, 5, 0);
        tick(); drive(1, 4, 0, 1, 4, 1, 1, 1); expect_out("mem_ack_loaduse", EN_LU, 1, 6, 0);
        tick(); drive(1, 4, 0, 0, 4, 1, 0, 0); expect_out("branch_after_wait", EN_BR, 1, 7, 0);

        // timeout into ERROR
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("to_miss", EN_OFF, 1, 7, 0);
        for (int i = 0; i < 16; i++) begin
            tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("to_wait", EN_OFF, 1, 32'(8 + i), 0);
        end
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 1); expect_out("err_late_ack", EN_OFF, 1, 24, 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); expect_out("err_nostart", EN_OFF, 1, 24, 1);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("err_restart", EN_OFF, 1, 24, 1);

        // reset clears error; async reset in MEM_WAIT
        tick(); rst_i = 1'b0; expect_out("err_reset", EN_OFF, 1, 0, 0);
        tick(); rst_i = 1'b1; drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("idle_after_err", EN_OFF, 1, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("rst_miss", EN_OFF, 1, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("rst_wait", EN_OFF, 1, 1, 0);
        tick(); rst_i = 1'b0; drive(1, 0, 0, 0, 0, 0, 1, 1); expect_out("async_rst", EN_OFF, 1, 0, 0);
        tick(); rst_i = 1'b1; drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("idle_after_rst", EN_OFF, 1, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("run_after_rst", EN_ALL, 1, 0, 0);

        // start_i dropped in RUN and in MEM_WAIT
        tick(); drive(0, 0, 0, 0, 0, 1, 0, 0); expect_out("stop_in_run", EN_OFF, 1, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("idle_after_stop", EN_OFF, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("run_restart", EN_ALL, 0, 0, 0);
        tick(); drive(1, 0, 0, 0, 0, 0, 1, 0); expect_out("miss_before_stop", EN_OFF, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 1, 1); expect_out("stop_in_wait", EN_OFF, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0); expect_out("idle_stopped", EN_OFF, 0, 0, 0);

        // 20 load-use stalls: 32-bit counter reaches 20, 4-bit one holds at 15
        tick(); rst_i = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0); expect_out("sat_reset", EN_OFF, 1, 0, 0);
        tick(); rst_i = 1'b1; drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("sat_idle", EN_OFF, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(); drive(1, 3, 0, 1, 3, 0, 0, 0); expect_out("lu_sat", EN_LU, 1, 32'(i), 0);
        end
        tick(); drive(1, 0, 0, 0, 0, 0, 0, 0); expect_out("sat_end", EN_ALL, 1, 20, 0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
